// File: rtl/ofm_write_scheduler.sv
// ofm_write_scheduler: arbitrates the OFM buffer write port between conv write-back and softmax bursts.
// Define WRITE_SCHED_SM_PRIORITY_EN for fixed softmax priority on ties; default is round-robin.
module ofm_write_scheduler #(
    parameter int ADDR_WIDTH = 16,
    parameter int CONV_BURST = 4,
    parameter int SM_BURST   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  conv_req,
    input  logic [ADDR_WIDTH-1:0] conv_base,
    input  logic                  sm_req,
    input  logic [ADDR_WIDTH-1:0] sm_base,
    input  logic                  stall,
    output logic                  conv_grant,
    output logic                  sm_grant,
    output logic                  conv_done,
    output logic                  sm_done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [3:0]            wr_sel,
    output logic                  wr_src,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, CONV_B, SM_B, DONE} state_t;
    localparam logic [3:0] CONV_LAST = 4'(CONV_BURST - 1);
    localparam logic [3:0] SM_LAST   = 4'(SM_BURST - 1);
    state_t                r_state, w_next;
    logic                  r_last_src, r_conv_grant, r_sm_grant, r_conv_done, r_sm_done;
    logic                  r_wr_en, r_wr_src, r_busy;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [3:0]            r_wr_sel;
    logic                  w_acc, w_last, w_tie_sm, w_pick_sm, w_start;
    always_comb begin
        w_acc = r_wr_en && !stall;
        w_last = w_acc && (r_wr_sel == (r_wr_src ? SM_LAST : CONV_LAST));
`ifdef WRITE_SCHED_SM_PRIORITY_EN
        w_tie_sm = 1'b1;
`else
        w_tie_sm = !r_last_src;
`endif
        w_pick_sm = sm_req && (!conv_req || w_tie_sm);
        w_next = r_state;
        case (r_state)
            IDLE:         w_next = (conv_req || sm_req) ? (w_pick_sm ? SM_B : CONV_B) : IDLE;
            CONV_B, SM_B: w_next = w_last ? DONE : r_state;
            default:      w_next = IDLE;
        endcase
        w_start = (r_state == IDLE) && (w_next != IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_src   <= 1'b1;
            r_conv_grant <= 1'b0;
            r_sm_grant   <= 1'b0;
            r_conv_done  <= 1'b0;
            r_sm_done    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_sel     <= '0;
            r_wr_src     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_conv_grant <= w_start && !w_pick_sm;
            r_sm_grant   <= w_start && w_pick_sm;
            r_conv_done  <= w_last && !r_wr_src;
            r_sm_done    <= w_last && r_wr_src;
            r_busy       <= w_next != IDLE;
            if (w_start) begin
                r_wr_en   <= 1'b1;
                r_wr_sel  <= '0;
                r_wr_src  <= w_pick_sm;
                r_wr_addr <= w_pick_sm ? sm_base : conv_base;
            end else if (w_last) begin
                r_wr_en    <= 1'b0;
                r_wr_sel   <= '0;
                r_last_src <= r_wr_src;
            end else if (w_acc) begin
                r_wr_sel  <= r_wr_sel + 4'd1;
                r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
            end
        end
    end
    assign conv_grant = r_conv_grant;
    assign sm_grant   = r_sm_grant;
    assign conv_done  = r_conv_done;
    assign sm_done    = r_sm_done;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_sel     = r_wr_sel;
    assign wr_src     = r_wr_src;
    assign busy       = r_busy;
endmodule

// File: tb/tb_ofm_write_scheduler.sv
// tb_ofm_write_scheduler: directed self-checking bench for ofm_write_scheduler.
module tb_ofm_write_scheduler;
    logic        clk = 1'b0;
    logic        rst, conv_req, sm_req, stall;
    logic [15:0] conv_base, sm_base, wr_addr;
    logic        conv_grant, sm_grant, conv_done, sm_done, wr_en, wr_src, busy;
    logic [3:0]  wr_sel;
    int          total = 0;
    int          bad = 0;
    int          en_cnt;
    logic        seen;
    always #5 clk = ~clk;
    ofm_write_scheduler #(.ADDR_WIDTH(16), .CONV_BURST(4), .SM_BURST(10)) dut (
        .clk(clk), .rst(rst), .conv_req(conv_req), .conv_base(conv_base),
        .sm_req(sm_req), .sm_base(sm_base), .stall(stall),
        .conv_grant(conv_grant), .sm_grant(sm_grant), .conv_done(conv_done),
        .sm_done(sm_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_src(wr_src), .busy(busy)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1; conv_req = 1'b0; sm_req = 1'b0; stall = 1'b0;
        conv_base = '0; sm_base = '0;
        tick(); tick();
        rst = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("idle_timeout", 32'(busy), 0);
    endtask
    task automatic all_zero(input string tag);
        chk({tag, "_outs"}, {23'd0, conv_grant, sm_grant, conv_done, sm_done, wr_en, wr_src, busy, 2'b0}, 0);
        chk({tag, "_addr"}, 32'(wr_addr), 0);
        chk({tag, "_sel"}, 32'(wr_sel), 0);
    endtask
    initial begin
        do_reset();
        all_zero("reset");
        // single conv burst
        conv_req = 1'b1; conv_base = 16'h0100;
        tick();
        conv_req = 1'b0; conv_base = 16'hdead;
        chk("conv_grant", 32'(conv_grant), 1);
        chk("conv_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            chk("conv_en", 32'(wr_en), 1);
            chk("conv_sel", 32'(wr_sel), 32'(i));
            chk("conv_addr", 32'(wr_addr), 32'h100 + 32'(i));
            chk("conv_src", 32'(wr_src), 0);
            if (i > 0) chk("conv_grant_pulse", 32'(conv_grant), 0);
            chk("conv_done_early", 32'(conv_done), 0);
            tick();
        end
        chk("conv_done", 32'(conv_done), 1);
        chk("conv_done_en", 32'(wr_en), 0);
        chk("conv_done_sel", 32'(wr_sel), 0);
        chk("conv_done_busy", 32'(busy), 1);
        tick();
        chk("conv_idle_busy", 32'(busy), 0);
        chk("conv_done_pulse", 32'(conv_done), 0);
        // single softmax burst
        sm_req = 1'b1; sm_base = 16'h0200;
        tick();
        sm_req = 1'b0; sm_base = 16'hbeef;
        chk("sm_grant", 32'(sm_grant), 1);
        for (int i = 0; i < 10; i++) begin
            chk("sm_en", 32'(wr_en), 1);
            chk("sm_sel", 32'(wr_sel), 32'(i));
            chk("sm_addr", 32'(wr_addr), 32'h200 + 32'(i));
            chk("sm_src", 32'(wr_src), 1);
            chk("sm_done_early", 32'(sm_done), 0);
            tick();
        end
        chk("sm_done", 32'(sm_done), 1);
        chk("sm_done_en", 32'(wr_en), 0);
        tick();
        chk("sm_idle_busy", 32'(busy), 0);
        // simultaneous requests held from reset
        do_reset();
        conv_req = 1'b1; sm_req = 1'b1; conv_base = 16'h0010; sm_base = 16'h0020;
        for (int t = 0; t <= 24; t++) begin
            logic ec, es;
            if (t == 0) tick();
`ifdef WRITE_SCHED_SM_PRIORITY_EN
            ec = 1'b0;
            es = (t % 12) == 0;
`else
            ec = (t == 0) || (t == 18);
            es = (t == 6) || (t == 24);
`endif
            chk("tie_conv_grant", 32'(conv_grant), 32'(ec));
            chk("tie_sm_grant", 32'(sm_grant), 32'(es));
            if (t < 24) tick();
        end
        conv_req = 1'b0; sm_req = 1'b0;
        wait_idle();
        tick();
        // stall on beat 2 for three cycles
        conv_req = 1'b1; conv_base = 16'h0300;
        tick();
        conv_req = 1'b0;
        en_cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            logic [3:0] es;
            es = (c < 2) ? 4'(c) : (c < 6) ? 4'd2 : 4'd3;
            stall = (c >= 2) && (c <= 4);
            if (conv_done) begin
                seen = 1'b1;
                chk("stall_done_cycle", 32'(c), 7);
            end else begin
                chk("stall_sel", 32'(wr_sel), 32'(es));
                chk("stall_addr", 32'(wr_addr), 32'h300 + 32'(es));
                en_cnt += 32'(wr_en);
                tick();
            end
        end
        stall = 1'b0;
        chk("stall_seen_done", 32'(seen), 1);
        chk("stall_en_cycles", 32'(en_cnt), 7);
        wait_idle();
        // address wrap
        conv_req = 1'b1; conv_base = 16'hfffe;
        tick();
        conv_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] ea;
            ea = 16'hfffe + 16'(i);
            chk("wrap_addr", 32'(wr_addr), 32'(ea));
            tick();
        end
        chk("wrap_done", 32'(conv_done), 1);
        wait_idle();
        // mid-burst reset during softmax beat 5
        sm_req = 1'b1; sm_base = 16'h0400;
        tick();
        sm_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_sel5", 32'(wr_sel), 5);
        rst = 1'b1;
        tick();
        all_zero("midrst");
        rst = 1'b0; conv_req = 1'b1; sm_req = 1'b1;
        tick();
        chk("midrst_no_done", 32'(sm_done), 0);
`ifdef WRITE_SCHED_SM_PRIORITY_EN
        chk("midrst_tie_sm", 32'(sm_grant), 1);
`else
        chk("midrst_tie_conv", 32'(conv_grant), 1);
        chk("midrst_tie_src", 32'(wr_src), 0);
`endif
        conv_req = 1'b0; sm_req = 1'b0;
        wait_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
